pb_gpio_debounce: RTL and testbench

//  PicoBlaze I/O-port peripheral: CHANNELS x 8-bit debounced switch inputs and CHANNELS x 8-bit LED outputs.

---
 rtl/pb_gpio_debounce_pkg.sv | 32 +++
 rtl/pb_gpio_debounce_bit.sv | 49 ++++
 rtl/pb_gpio_debounce.sv | 117 +++++++++++
 tb/tb_pb_gpio_debounce.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_gpio_debounce_pkg.sv
// Shared register-map offsets and small helpers for the PicoBlaze debounced GPIO peripheral.
package pb_gpio_debounce_pkg;

  localparam logic [1:0] GPIO_OFF_STATE = 2'd0;
  localparam logic [1:0] GPIO_OFF_LED   = 2'd1;
  localparam logic [1:0] GPIO_OFF_FLAG  = 2'd2;
  localparam logic [1:0] GPIO_OFF_MASK  = 2'd3;

  // A flag bit being set on the same edge as a firmware clear stays set, so no event is lost.
  function automatic logic [7:0] flag_update(input logic [7:0] flag,
                                             input logic [7:0] set,
                                             input logic [7:0] clr);
    return (flag & ~clr) | set;
  endfunction

  function automatic logic [7:0] reg_read(input logic [1:0] off,
                                          input logic [7:0] st,
                                          input logic [7:0] led,
                                          input logic [7:0] flag,
                                          input logic [7:0] mask);
    logic [7:0] val;
    case (off)
      GPIO_OFF_STATE: val = st;
      GPIO_OFF_LED:   val = led;
      GPIO_OFF_FLAG:  val = flag;
      GPIO_OFF_MASK:  val = mask;
      default:        val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/pb_gpio_debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a mismatch counter that accepts a new level
// after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module gpio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK_IN,
  input  logic RESET_N_IN,
  input  logic pin,
  output logic state,
  output logic change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          state_r;
  logic [CW-1:0] cnt_r;
  logic          done_s;

  // change is high in the cycle before the accepting edge so the owner's flag sets with STATE.
  assign done_s = (sync2_r != state_r) && (cnt_r == LAST_CNT);

  // Synchroniser and debounce counter; any agreement with STATE restarts the count.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      state_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= pin;
      sync2_r <= sync1_r;
      if (sync2_r == state_r) begin
        cnt_r <= '0;
      end else if (done_s) begin
        cnt_r   <= '0;
        state_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign state  = state_r;
  assign change = done_s;

endmodule

// File: rtl/pb_gpio_debounce.sv
// PicoBlaze port peripheral: CHANNELS x 8 debounced switches with change flags and masked
// interrupt, plus CHANNELS x 8 LED outputs.
module pb_gpio_debounce
  import pb_gpio_debounce_pkg::*;
#(
  parameter int         CHANNELS        = 1,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [7:0] BASE_ADDR       = 8'h00
) (
  input  logic                  CLK_IN,
  input  logic                  RESET_N_IN,
  input  logic [7:0]            PORT_ID,
  input  logic                  WRITE_STROBE,
  input  logic                  READ_STROBE,
  input  logic [7:0]            OUT_PORT,
  output logic [7:0]            IN_PORT,
  output logic                  INTERRUPT,
  input  logic                  INTERRUPT_ACK,
  input  logic [8*CHANNELS-1:0] SWITCHES,
  output logic [8*CHANNELS-1:0] LEDS
);

  localparam int NB   = 8 * CHANNELS;
  localparam int NREG = 4 * CHANNELS;

  logic [NB-1:0]       state_s;
  logic [NB-1:0]       change_s;
  logic [NB-1:0]       led_r;
  logic [NB-1:0]       flag_r;
  logic [NB-1:0]       mask_r;
  logic [7:0]          in_port_r;
  logic                evt_r;
  logic                irq_r;
  logic [7:0]          rel_addr_s;
  logic                addr_hit_s;
  logic [1:0]          off_s;
  logic [5:0]          chan_s;
  logic [CHANNELS-1:0] sel_s;
  logic [CHANNELS-1:0] wr_led_s;
  logic [CHANNELS-1:0] wr_flag_s;
  logic [CHANNELS-1:0] wr_mask_s;
  logic [7:0]          rd_data_s;
  logic                unused_s;

  assign unused_s = READ_STROBE;

  for (genvar i = 0; i < NB; i++) begin : g_bit
    gpio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .CLK_IN     (CLK_IN),
      .RESET_N_IN (RESET_N_IN),
      .pin        (SWITCHES[i]),
      .state      (state_s[i]),
      .change     (change_s[i])
    );
  end

  // Addresses below BASE_ADDR wrap to large offsets and fall outside the map.
  assign rel_addr_s = PORT_ID - BASE_ADDR;
  assign addr_hit_s = ({1'b0, rel_addr_s} < 9'(NREG));
  assign off_s      = rel_addr_s[1:0];
  assign chan_s     = rel_addr_s[7:2];

  // Per-channel address decode and write enables; STATE writes have no enable.
  always_comb begin
    sel_s     = '0;
    wr_led_s  = '0;
    wr_flag_s = '0;
    wr_mask_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sel_s[c]     = addr_hit_s && (chan_s == 6'(c));
      wr_led_s[c]  = WRITE_STROBE && sel_s[c] && (off_s == GPIO_OFF_LED);
      wr_flag_s[c] = WRITE_STROBE && sel_s[c] && (off_s == GPIO_OFF_FLAG);
      wr_mask_s[c] = WRITE_STROBE && sel_s[c] && (off_s == GPIO_OFF_MASK);
    end
  end

  // Read mux; at most one channel is selected, unmapped addresses give zero.
  always_comb begin
    rd_data_s = 8'h00;
    for (int c = 0; c < CHANNELS; c++) begin
      rd_data_s = rd_data_s | ({8{sel_s[c]}} &
                  reg_read(off_s, state_s[8*c +: 8], led_r[8*c +: 8],
                           flag_r[8*c +: 8], mask_r[8*c +: 8]));
    end
  end

  // Register file, read data and interrupt; the event is registered so INTERRUPT trails FLAG by one edge.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      led_r     <= '0;
      flag_r    <= '0;
      mask_r    <= '0;
      in_port_r <= 8'h00;
      evt_r     <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_led_s[c]) begin
          led_r[8*c +: 8] <= OUT_PORT;
        end
        if (wr_mask_s[c]) begin
          mask_r[8*c +: 8] <= OUT_PORT;
        end
        flag_r[8*c +: 8] <= flag_update(flag_r[8*c +: 8], change_s[8*c +: 8],
                                        {8{wr_flag_s[c]}} & OUT_PORT);
      end
      in_port_r <= rd_data_s;
      evt_r     <= |(change_s & mask_r);
      irq_r     <= evt_r | (irq_r & ~INTERRUPT_ACK);
    end
  end

  assign IN_PORT   = in_port_r;
  assign LEDS      = led_r;
  assign INTERRUPT = irq_r;

endmodule

// File: tb/tb_pb_gpio_debounce.sv
// Scoreboard bench for pb_gpio_debounce: a driver feeds directed and random port/pin traffic and
// queues per-cycle expectations from a behavioural model; a monitor pops and compares after each edge.
module tb_pb_gpio_debounce;

  localparam int         CH   = 2;
  localparam int         DC   = 16;
  localparam logic [7:0] BASE = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_want = 1'b0;
  logic [7:0]  port_id = 8'h00;
  logic        ws = 1'b0;
  logic        rs = 1'b0;
  logic [7:0]  od = 8'h00;
  logic        ack = 1'b0;
  logic [15:0] sw_pins = 16'h0;
  logic [15:0] sw = 16'h0;
  logic [7:0]  in_port;
  logic        irq;
  logic [15:0] leds;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  in_port;
    logic [15:0] leds;
    logic        irq;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [15:0] m_st, m_flag, m_mask, m_led;
  logic        m_irq, m_due;
  logic [7:0]  m_in;
  int          m_run[16];
  logic [15:0] m_hist[$];

  pb_gpio_debounce #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .BASE_ADDR(BASE)) dut (
    .CLK_IN        (clk),
    .RESET_N_IN    (rst_n),
    .PORT_ID       (port_id),
    .WRITE_STROBE  (ws),
    .READ_STROBE   (rs),
    .OUT_PORT      (od),
    .IN_PORT       (in_port),
    .INTERRUPT     (irq),
    .INTERRUPT_ACK (ack),
    .SWITCHES      (sw_pins),
    .LEDS          (leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = '0; m_flag = '0; m_mask = '0; m_led = '0;
    m_irq = 1'b0; m_due = 1'b0; m_in = 8'h00;
    for (int b = 0; b < 16; b++) m_run[b] = 0;
    m_hist.delete();
    m_hist.push_back(16'h0);
    m_hist.push_back(16'h0);
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    logic [7:0] rel;
    int ch;
    rel = a - BASE;
    if (rel >= 8'(4 * CH)) return 8'h00;
    ch = int'(rel[7:2]);
    case (rel[1:0])
      2'd0:    return m_st[ch*8 +: 8];
      2'd1:    return m_led[ch*8 +: 8];
      2'd2:    return m_flag[ch*8 +: 8];
      default: return m_mask[ch*8 +: 8];
    endcase
  endfunction

  // One clock edge of the model: pins reach the debouncer two edges late, a level is
  // accepted once it has disagreed with the stable value for DC edges in a row.
  task automatic model_edge(input logic [15:0] pins, input logic [7:0] pid,
                            input logic w, input logic [7:0] d, input logic a);
    logic [15:0] delayed, acc, clr, old_mask;
    logic [7:0]  rel;
    int          ch;
    delayed = m_hist.pop_front();
    m_hist.push_back(pins);
    acc = '0;
    for (int b = 0; b < 16; b++) begin
      if (delayed[b] !== m_st[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          acc[b] = 1'b1;
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_in = model_read(pid);
    old_mask = m_mask;
    clr = '0;
    rel = pid - BASE;
    ch = int'(rel[7:2]);
    if (w && rel < 8'(4 * CH)) begin
      case (rel[1:0])
        2'd1:    m_led[ch*8 +: 8] = d;
        2'd2:    clr[ch*8 +: 8] = d;
        2'd3:    m_mask[ch*8 +: 8] = d;
        default: ;
      endcase
    end
    m_flag = (m_flag & ~clr) | acc;
    m_st = m_st ^ acc;
    m_irq = m_due | (m_irq & ~a);
    m_due = |(acc & old_mask);
  endtask

  task automatic step(input logic [7:0] pid, input logic w, input logic [7:0] d,
                      input logic a, input logic r);
    exp_t e;
    @(negedge clk);
    rst_n = rst_want; port_id = pid; ws = w; od = d; ack = a; rs = r; sw_pins = sw;
    if (rst_want) model_edge(sw, pid, w, d, a);
    else model_reset();
    e.in_port = m_in; e.leds = m_led; e.irq = m_irq;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [7:0] a);
    step(a, 1'b0, 8'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(a, 1'b1, d, 1'b0, 1'($urandom));
  endtask

  // Monitor: every edge that has a queued expectation is checked just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("leds", leds, e.leds);
      chk("interrupt", 16'(irq), 16'(e.irq));
      chk("in_port", 16'(in_port), 16'(e.in_port));
    end
  end

  initial begin
    int hold;
    logic [15:0] flip;
    logic [7:0]  pid;
    int op;
    model_reset();
    for (int i = 0; i < 3; i++) rd(8'h10);
    rst_want = 1'b1;

    // T1: LED write and readback
    wr(8'h11, 8'hA5);
    rd(8'h11);
    rd(8'h15);
    // T2: channel 1 all high, accepted after exactly 2+DC edges
    sw[15:8] = 8'hFF;
    for (int i = 0; i < 22; i++) rd(8'h14);
    rd(8'h16);
    // T3: short glitch then a held level
    sw[0] = 1'b1;
    for (int i = 0; i < 10; i++) rd(8'h10);
    sw[0] = 1'b0;
    for (int i = 0; i < 20; i++) rd((i % 2 == 0) ? 8'h10 : 8'h12);
    sw[0] = 1'b1;
    for (int i = 0; i < 22; i++) rd((i % 2 == 0) ? 8'h10 : 8'h12);
    // T4: masked interrupt, ack, flag clear, set-wins coincidences
    wr(8'h13, 8'h01);
    wr(8'h12, 8'hFF);
    sw[0] = 1'b0;
    for (int i = 0; i < 20; i++) rd(8'h12);
    step(8'h12, 1'b0, 8'h00, 1'b1, 1'b0);
    wr(8'h12, 8'h01);
    rd(8'h12);
    sw[0] = 1'b1;
    for (int i = 0; i < 20; i++) rd(8'h12);
    sw[0] = 1'b0;
    for (int i = 0; i < 17; i++) rd(8'h12);
    wr(8'h12, 8'h01);
    step(8'h12, 1'b0, 8'h00, 1'b1, 1'b0);
    rd(8'h12);
    rd(8'h11);
    // T5: asynchronous reset part-way through a count, one pin held high through reset
    sw[1] = 1'b1;
    for (int i = 0; i < 12; i++) rd(8'h11);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    rst_want = 1'b0;
    #1;
    chk("async_leds", leds, 16'h0000);
    chk("async_irq", 16'(irq), 16'h0000);
    chk("async_in_port", 16'(in_port), 16'h0000);
    model_reset();
    sw[1] = 1'b0;
    sw[15] = 1'b1;
    for (int i = 0; i < 3; i++) rd(8'h10);
    rst_want = 1'b1;
    for (int i = 0; i < 40; i++) rd((i % 3 == 0) ? 8'h12 : ((i % 3 == 1) ? 8'h10 : 8'h16));
    // T6: unmapped reads, ignored STATE write, READ_STROBE low
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(8'h18, 1'b0, 8'h00, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    step(8'h10, 1'b1, 8'h5A, 1'b0, 1'b0);
    step(8'h14, 1'b0, 8'h00, 1'b0, 1'b0);
    step(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic: pin edges with mixed short and long holds, random port accesses and acks
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        flip = 16'(1 << $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) flip = flip | 16'($urandom);
        sw = sw ^ flip;
        hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : $urandom_range(16, 40);
      end
      hold--;
      op = $urandom_range(0, 9);
      pid = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(BASE + 8'($urandom_range(0, 7)));
      step(pid, op < 3, 8'($urandom), $urandom_range(0, 7) == 0, 1'($urandom));
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
